hpc3_rand_source: RTL and testbench

HPC3_RAND_SOURCE -- requirements
Module: hpc3_rand_source

---
 rtl/hpc3_rand_source.sv | 111 +++++++++++
 tb/tb_hpc3_rand_source.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hpc3_rand_source.sv
// hpc3_rand_source: 64-bit LFSR randomness source feeding N_GADGETS hpc3 AND gadgets
//
// Ports:
//   clk         single rising-edge clock
//   rst         asynchronous active-high reset
//   seed_valid  seed_data is offered
//   seed_ready  a seed is accepted this cycle (IDLE only)
//   seed_data   64-bit seed; zero is replaced by 64'h1
//   en          consumer takes the current word and requests the next
//   rand_valid  rand_out carries fresh, never-consumed bits
//   rand_out    bit 2k = randa, bit 2k+1 = randb of gadget k
//
// Optional feature: define RAND_RESEED_EN to return to IDLE after
// RESEED_PERIOD consumptions and demand a new seed.
module hpc3_rand_source #(
    parameter int N_GADGETS     = 4,
    parameter int WARMUP        = 16,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_valid,
    output logic                   seed_ready,
    input  logic [63:0]            seed_data,
    input  logic                   en,
    output logic                   rand_valid,
    output logic [2*N_GADGETS-1:0] rand_out
);
    localparam int W = 2 * N_GADGETS;

    typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

    state_t         state_q, state_d;
    logic [63:0]    s_q, s_d, s_adv;
    logic [W-1:0]   rand_q, rand_d, fbs;
    logic           valid_q, valid_d;
    logic [7:0]     warm_q, warm_d;
    logic           load, adv, consume, warm_done, period_done;

    // W chained LFSR steps; fbs[i] is the feedback bit of step i
    always_comb begin
        s_adv = s_q;
        fbs   = '0;
        for (int i = 0; i < W; i++) begin
            fbs[i] = s_adv[63] ^ s_adv[62] ^ s_adv[60] ^ s_adv[59];
            s_adv  = {s_adv[62:0], fbs[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = load ? WARM : IDLE;
            WARM:    state_d = warm_done ? RUN : WARM;
            RUN:     state_d = period_done ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seed_ready = state_q == IDLE;
        load       = seed_ready && seed_valid;
        consume    = state_q == RUN && en && valid_q;
        adv        = state_q == WARM || consume;
        warm_done  = warm_q == 8'(WARMUP - 1);
    end

`ifdef RAND_RESEED_EN
    logic [15:0] cons_q, cons_d;
    assign period_done = consume && cons_q == 16'(RESEED_PERIOD - 1);
    assign cons_d      = state_q != RUN ? 16'd0 :
                         period_done    ? 16'd0 :
                         consume        ? cons_q + 16'd1 : cons_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cons_q <= '0;
        else     cons_q <= cons_d;
    end
`else
    assign period_done = 1'b0;
`endif

    // Output word is only replaced on an advance, so consumed bits never reappear
    always_comb begin
        s_d     = load ? (seed_data == 64'd0 ? 64'h1 : seed_data) : adv ? s_adv : s_q;
        rand_d  = adv ? fbs : rand_q;
        valid_d = (state_q == WARM && warm_done) || (state_q == RUN && valid_q && !period_done);
        warm_d  = state_q == WARM ? warm_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            rand_q  <= '0;
            valid_q <= 1'b0;
            warm_q  <= '0;
        end else begin
            s_q     <= s_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
            warm_q  <= warm_d;
        end
    end

    assign rand_valid = valid_q;
    assign rand_out   = rand_q;
endmodule

// File: tb/tb_hpc3_rand_source.sv
// tb_hpc3_rand_source: self-checking bench for hpc3_rand_source against a bit-serial LFSR model
module tb_hpc3_rand_source;
    localparam int NG = 4;
    localparam int W  = 2 * NG;
    localparam int WU = 16;

    typedef struct packed {
        logic en;
        logic sv;
        logic adv;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sv, sv4, en, en4;
    logic [63:0]  sd, sd4;
    logic         ready, ready4, valid, valid4;
    logic [W-1:0] rout, rout4;

    int           nvec = 0;
    int           nerr = 0;
    logic [63:0]  m_s;
    logic [W-1:0] m_word;
    vec_t         tbl[4];

    hpc3_rand_source #(.N_GADGETS(NG), .WARMUP(WU)) dut (
        .clk(clk), .rst(rst), .seed_valid(sv), .seed_ready(ready), .seed_data(sd),
        .en(en), .rand_valid(valid), .rand_out(rout)
    );

    hpc3_rand_source #(.N_GADGETS(NG), .WARMUP(WU), .RESEED_PERIOD(4)) dut4 (
        .clk(clk), .rst(rst), .seed_valid(sv4), .seed_ready(ready4), .seed_data(sd4),
        .en(en4), .rand_valid(valid4), .rand_out(rout4)
    );

    always #5 clk = ~clk;

    // Bit-serial reference: one word = W single LFSR steps, bit i from step i
    function automatic logic [W-1:0] m_adv();
        logic [W-1:0] r;
        logic fb;
        for (int i = 0; i < W; i++) begin
            fb   = m_s[63] ^ m_s[62] ^ m_s[60] ^ m_s[59];
            r[i] = fb;
            m_s  = {m_s[62:0], fb};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic seed_dut(input logic [63:0] d);
        sv = 1'b1;
        sd = d;
        @(negedge clk);
        m_s = d == 64'd0 ? 64'h1 : d;
        check("ready_drop", 64'(ready), 64'd0);
    endtask

    // Counts low-valid cycles of warm-up while hammering en/seed_valid, then checks the first word
    task automatic warm_up(input string name);
        int lows = 0;
        while (!valid && lows < 40) begin
            check("warm_ready", 64'(ready), 64'd0);
            lows++;
            en = 1'($urandom);
            sv = 1'($urandom);
            sd = {$urandom, $urandom};
            @(negedge clk);
        end
        check(name, 64'(lows), 64'(WU));
        repeat (WU) m_word = m_adv();
        check("first_word", 64'(rout), 64'(m_word));
    endtask

    initial begin
        int cnt;
        tbl[0] = '{en: 1'b1, sv: 1'b1, adv: 1'b1};
        tbl[1] = '{en: 1'b0, sv: 1'b1, adv: 1'b0};
        tbl[2] = '{en: 1'b0, sv: 1'b0, adv: 1'b0};
        tbl[3] = '{en: 1'b1, sv: 1'b1, adv: 1'b1};
        sv = 0; sd = 0; en = 0; sv4 = 0; sd4 = 0; en4 = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_out", 64'(rout), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(ready), 64'd1);

        // zero seed becomes 1, seed_valid kept high during warm-up
        seed_dut(64'd0);
        sd = 64'hDEAD_BEEF_0000_1234;
        warm_up("warm_lows_zero_seed");

        // en 1,0,0,1 with stray seeds: exactly two advances
        for (int k = 0; k < 4; k++) begin
            en = tbl[k].en;
            sv = tbl[k].sv;
            sd = {$urandom, $urandom};
            @(negedge clk);
            if (tbl[k].adv) m_word = m_adv();
            check("tbl_out", 64'(rout), 64'(m_word));
            check("tbl_valid", 64'(valid), 64'd1);
            check("tbl_ready", 64'(ready), 64'd0);
        end

        // random en / seed_valid in RUN
        for (int k = 0; k < 200; k++) begin
            en = 1'($urandom);
            sv = 1'($urandom);
            sd = {$urandom, $urandom};
            @(negedge clk);
            if (en) m_word = m_adv();
            check("rand_out", 64'(rout), 64'(m_word));
            check("rand_valid", 64'(valid), 64'd1);
        end

        // asynchronous reset mid-RUN
        en = 1'b1; sv = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_valid", 64'(valid), 64'd0);
        check("async_out", 64'(rout), 64'd0);
        check("async_ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", 64'(ready), 64'd1);
        repeat (3) @(negedge clk);
        check("no_valid_without_seed", 64'(valid), 64'd0);

        // known seed, continuous consumption
        en = 1'b0;
        seed_dut(64'h0123_4567_89AB_CDEF);
        sv = 1'b0;
        warm_up("warm_lows_seed");
        en = 1'b1; sv = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            m_word = m_adv();
            check("stream_out", 64'(rout), 64'(m_word));
            check("stream_valid", 64'(valid), 64'd1);
        end
        en = 1'b0;

        // reseed period on the second instance
        sv4 = 1'b1;
        sd4 = {$urandom, $urandom};
        @(negedge clk);
        sv4 = 1'b0;
        cnt = 0;
        while (!valid4 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("dut4_warm_lows", 64'(cnt), 64'(WU));
        en4 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid4) cnt++;
            @(negedge clk);
        end
`ifdef RAND_RESEED_EN
        check("reseed_words", 64'(cnt), 64'd4);
        check("reseed_ready", 64'(ready4), 64'd1);
`else
        check("reseed_words", 64'(cnt), 64'd10);
        check("reseed_ready", 64'(ready4), 64'd0);
`endif
        en4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
